// File: rtl/flappy_pkg.sv
// Shared types and constants for the scrolling pipe column generator.
package flappy_pkg;

  typedef enum logic {
    SPACE = 1'b0,
    PIPE  = 1'b1
  } state_e;

  localparam logic [3:0] LFSR_SEED = 4'b0001;
  localparam int         ROWS      = 8;

endpackage

// File: rtl/pipe_lfsr.sv
// 4-bit maximal-length LFSR (x^4+x^3+1), free-running on every clk edge outside reset.
module pipe_lfsr
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] value_o
);

  logic [3:0] lfsr_q;
  logic [3:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/pipe_column_gen.sv
// Emits the next scrolling column: SPACING empty columns, then PIPE_WIDTH pipe columns
// with a pseudo-random gap; everything registered, frozen while lose is high.
module pipe_column_gen
  import flappy_pkg::*;
#(
  parameter int SPACING    = 3,
  parameter int PIPE_WIDTH = 2,
  parameter int GAP_HEIGHT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cycle,
  input  logic       lose,
  output logic [7:0] col_pattern,
  output logic       new_pipe
);

  localparam int MAX_TOP = ROWS - GAP_HEIGHT;

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [2:0] gap_q, gap_d;
  logic [7:0] col_q, col_d;
  logic       np_q, np_d;

  logic [3:0] lfsr;
  logic [2:0] gap_new;
  logic       lfsr_unused;

  pipe_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .value_o (lfsr)
  );

  assign lfsr_unused = lfsr[3];

  function automatic logic [7:0] pipe_mask(input logic [2:0] gap);
    logic [7:0] m;
    m = 8'hFF;
    for (int r = 0; r < ROWS; r++) begin
      if (r >= int'(gap) && r < int'(gap) + GAP_HEIGHT) m[r] = 1'b0;
    end
    return m;
  endfunction

  // Out-of-range LFSR values fold back to the bottom so the gap never wraps.
  always_comb begin
    if (int'(lfsr[2:0]) <= MAX_TOP) gap_new = lfsr[2:0];
    else                            gap_new = lfsr[2:0] - 3'(MAX_TOP + 1);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gap_d   = gap_q;
    col_d   = col_q;
    np_d    = 1'b0;
    if (cycle && !lose) begin
      case (state_q)
        SPACE: begin
          if (count_q == 3'(SPACING - 1)) begin
            state_d = PIPE;
            count_d = 3'd0;
            gap_d   = gap_new;
            col_d   = pipe_mask(gap_new);
            np_d    = 1'b1;
          end else begin
            count_d = count_q + 3'd1;
            col_d   = 8'h00;
          end
        end
        PIPE: begin
          if (count_q == 3'(PIPE_WIDTH - 1)) begin
            state_d = SPACE;
            count_d = 3'd0;
            col_d   = 8'h00;
          end else begin
            count_d = count_q + 3'd1;
            col_d   = pipe_mask(gap_q);
          end
        end
        default: begin
          state_d = SPACE;
          count_d = 3'd0;
          col_d   = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SPACE;
      count_q <= 3'd0;
      gap_q   <= 3'd0;
      col_q   <= 8'h00;
      np_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      col_q   <= col_d;
      np_q    <= np_d;
    end
  end

  assign col_pattern = col_q;
  assign new_pipe    = np_q;

endmodule

// File: tb/tb_pipe_column_gen.sv
// Self-checking bench for pipe_column_gen: vector table, corner sequences, random run vs model.
module tb_pipe_column_gen;

  localparam int S = 3;
  localparam int W = 2;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cycle;
  logic       lose;
  logic [7:0] col_pattern;
  logic       new_pipe;

  int errors = 0;
  int checks = 0;

  pipe_column_gen #(.SPACING(S), .PIPE_WIDTH(W), .GAP_HEIGHT(G)) dut (
    .clk         (clk),
    .reset       (reset),
    .cycle       (cycle),
    .lose        (lose),
    .col_pattern (col_pattern),
    .new_pipe    (new_pipe)
  );

  always #5 clk = ~clk;

  // Model: column index since reset decides space/pipe; LFSR tracked as an integer.
  int         m_lfsr;
  int         m_idx;
  int         m_gap;
  logic [7:0] m_col;
  logic       m_np;

  function automatic int lfsr_next(input int l);
    return ((l << 1) & 14) | (((l >> 3) ^ (l >> 2)) & 1);
  endfunction

  function automatic logic [7:0] mask_of(input int gap);
    logic [7:0] m;
    for (int r = 0; r < 8; r++) m[r] = !(r >= gap && r < gap + G);
    return m;
  endfunction

  function automatic int gap_of(input int l);
    int v;
    v = l & 7;
    return (v <= 8 - G) ? v : v - (8 - G + 1);
  endfunction

  function automatic logic gap_shape_ok(input logic [7:0] c);
    int f;
    f = -1;
    for (int r = 7; r >= 0; r--) if (c[r] == 1'b0) f = r;
    if (f < 0 || f > 8 - G) return 1'b0;
    return c == mask_of(f);
  endfunction

  task automatic model_reset();
    m_lfsr = 1; m_idx = 0; m_gap = 0; m_col = 8'h00; m_np = 1'b0;
  endtask

  task automatic model_edge(input bit cyc, input bit ls);
    int phase;
    m_np = 1'b0;
    if (cyc && !ls) begin
      m_idx++;
      phase = m_idx % (S + W);
      if (phase == S) begin
        m_gap = gap_of(m_lfsr);
        m_np  = 1'b1;
      end
      m_col = (phase < S) ? 8'h00 : mask_of(m_gap);
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit cyc, input bit ls);
    cycle = cyc;
    lose  = ls;
    @(posedge clk);
    model_edge(cyc, ls);
    #1;
    check8("col_pattern", col_pattern, m_col);
    check1("new_pipe", new_pipe, m_np);
  endtask

  // Asserted between edges; outputs must clear before any clk edge arrives.
  task automatic apply_reset();
    cycle = 1'b0;
    lose  = 1'b0;
    reset = 1'b1;
    #2;
    check8("async_reset_col", col_pattern, 8'h00);
    check1("async_reset_np", new_pipe, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         cyc;
    bit         ls;
    logic [7:0] col;
    bit         np;
  } vec_t;

  vec_t vec [8];

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      step(vec[i].cyc, vec[i].ls);
      check8($sformatf("table_col_e%0d", i + 1), col_pattern, vec[i].col);
      check1($sformatf("table_np_e%0d", i + 1), new_pipe, vec[i].np);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int np_edges[$];
    int pipe_cols;
    int prev_idx;

    vec[0] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vec[1] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vec[2] = '{1'b1, 1'b0, 8'h8F, 1'b1};
    vec[3] = '{1'b1, 1'b0, 8'h8F, 1'b0};
    vec[4] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vec[5] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vec[6] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vec[7] = '{1'b1, 1'b0, 8'hE3, 1'b1};

    cycle = 1'b0;
    lose  = 1'b0;
    reset = 1'b1;
    apply_reset();
    run_table();

    // Reset lands while the E3 pipe column is showing; sequence must restart cleanly.
    apply_reset();
    run_table();

    // Freeze during the pipe, then resume.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      check8("lose_hold_col", col_pattern, 8'h8F);
      check1("lose_hold_np", new_pipe, 1'b0);
    end
    step(1'b1, 1'b0);
    check8("lose_resume_col", col_pattern, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      check8("lose_resume_space", col_pattern, 8'h00);
    end
    step(1'b1, 1'b0);
    check1("lose_resume_newpipe", new_pipe, 1'b1);
    step(1'b1, 1'b1);
    apply_reset();
    run_table();

    // Cycle gating at half rate.
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      step((i % 2) == 0, 1'b0);
      if (new_pipe === 1'b1) np_edges.push_back(i);
    end
    checks++;
    if (np_edges.size() != 3) begin
      errors++;
      $display("FAIL gating_pulses: got %0d pulses, expected 3", np_edges.size());
    end else begin
      check8("gating_period_a", 8'(np_edges[1] - np_edges[0]), 8'(2 * (S + W)));
      check8("gating_period_b", 8'(np_edges[2] - np_edges[1]), 8'(2 * (S + W)));
    end

    // Steer latches onto LFSR low bits 6 and 7 to exercise gap folding.
    apply_reset();
    for (int t = 6; t <= 7; t++) begin
      for (int n = 0; n < 10 && (m_idx % (S + W)) != S - 1; n++) step(1'b1, 1'b0);
      for (int n = 0; n < 30 && (m_lfsr & 7) != t; n++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check8($sformatf("clamp_v%0d", t), col_pattern, (t == 6) ? 8'hF8 : 8'hF1);
      check1($sformatf("clamp_np_v%0d", t), new_pipe, 1'b1);
    end

    // Random scroll/freeze traffic against the model.
    apply_reset();
    pipe_cols = 0;
    for (int n = 0; n < 20000 && pipe_cols < 500; n++) begin
      prev_idx = m_idx;
      step(($urandom % 4) != 0, ($urandom % 8) == 0);
      if (m_idx != prev_idx && (m_idx % (S + W)) >= S) begin
        pipe_cols++;
        check1("gap_shape", gap_shape_ok(col_pattern), 1'b1);
      end
    end
    checks++;
    if (pipe_cols < 500) begin
      errors++;
      $display("FAIL random_budget: got %0d pipe columns, expected 500", pipe_cols);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
